// File: rtl/time_counter.sv
// rtl/time_counter.sv - 24-hour hour/min/sec timekeeper with scan strobe and two-key set mode
module time_counter #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int SCAN_DIV  = 50_000,
    parameter int INIT_HOUR = 22,
    parameter int INIT_MIN  = 46,
    parameter int INIT_SEC  = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       flag_scan,
    output logic       sec_pulse,
    output logic [1:0] mode
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_e;

    mode_e         mode_q;
    logic [TW-1:0] tick_cnt_q;
    logic [SW-1:0] scan_cnt_q;
    logic [4:0]    hour_q;
    logic [5:0]    min_q;
    logic [5:0]    sec_q;
    logic          flag_scan_q;
    logic          sec_pulse_q;

    logic [4:0] hour_inc_d, hour_tick_d;
    logic [5:0] min_inc_d, min_tick_d, sec_tick_d;
    logic       sec_wrap, min_wrap;

    // Field increments double as the carry chain for a second tick.
    always_comb begin
        sec_wrap    = (sec_q == 6'd59);
        min_wrap    = (min_q == 6'd59);
        hour_inc_d  = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        min_inc_d   = min_wrap ? 6'd0 : min_q + 6'd1;
        sec_tick_d  = sec_wrap ? 6'd0 : sec_q + 6'd1;
        min_tick_d  = sec_wrap ? min_inc_d : min_q;
        hour_tick_d = (sec_wrap && min_wrap) ? hour_inc_d : hour_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= RUN;
            tick_cnt_q  <= '0;
            scan_cnt_q  <= '0;
            hour_q      <= 5'(INIT_HOUR);
            min_q       <= 6'(INIT_MIN);
            sec_q       <= 6'(INIT_SEC);
            flag_scan_q <= 1'b0;
            sec_pulse_q <= 1'b0;
        end else begin
            scan_cnt_q  <= (scan_cnt_q == SCAN_MAX) ? '0 : scan_cnt_q + 1'b1;
            flag_scan_q <= (scan_cnt_q == SCAN_MAX);
            sec_pulse_q <= 1'b0;

            case (mode_q)
                RUN: begin
                    // A mode change discards a tick landing on the same edge.
                    if (key_mode) begin
                        mode_q     <= SET_HOUR;
                        tick_cnt_q <= '0;
                    end else if (tick_cnt_q == TICK_MAX) begin
                        tick_cnt_q  <= '0;
                        sec_pulse_q <= 1'b1;
                        sec_q       <= sec_tick_d;
                        min_q       <= min_tick_d;
                        hour_q      <= hour_tick_d;
                    end else begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                    end
                end
                SET_HOUR: begin
                    tick_cnt_q <= '0;
                    if (key_mode) begin
                        mode_q <= SET_MIN;
                    end else if (key_inc) begin
                        hour_q <= hour_inc_d;
                    end
                end
                SET_MIN: begin
                    tick_cnt_q <= '0;
                    if (key_mode) begin
                        mode_q <= RUN;
                        sec_q  <= 6'd0;
                    end else if (key_inc) begin
                        min_q <= min_inc_d;
                    end
                end
                default: begin
                    mode_q     <= RUN;
                    tick_cnt_q <= '0;
                end
            endcase
        end
    end

    assign hour      = hour_q;
    assign min       = min_q;
    assign sec       = sec_q;
    assign flag_scan = flag_scan_q;
    assign sec_pulse = sec_pulse_q;
    assign mode      = mode_q;

endmodule

// File: tb/tb_time_counter.sv
// tb/tb_time_counter.sv - self-checking bench for time_counter with a seconds-of-day reference model
module tb_time_counter;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 3;
    localparam int T0 = 22 * 3600 + 46 * 60 + 40;

    logic       clk;
    logic       rst;
    logic       key_mode;
    logic       key_inc;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       flag_scan;
    logic       sec_pulse;
    logic [1:0] mode;

    int checks;
    int failures;

    time_counter #(
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV),
        .INIT_HOUR(22),
        .INIT_MIN (46),
        .INIT_SEC (40)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_mode (key_mode),
        .key_inc  (key_inc),
        .hour     (hour),
        .min      (min),
        .sec      (sec),
        .flag_scan(flag_scan),
        .sec_pulse(sec_pulse),
        .mode     (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Model: time is seconds-of-day; ticks and scan strobes follow from edge counts.
    int m_cyc;
    int m_ref;
    int m_tod;
    int m_mode;
    bit m_pulse;
    bit m_flag;
    bit m_valid;

    initial m_valid = 1'b0;

    always @(posedge clk) begin : model
        int n_cyc, n_ref, n_tod, n_mode, h, m;
        bit n_pulse;
        if (rst) begin
            m_cyc   <= 0;
            m_ref   <= 0;
            m_tod   <= T0;
            m_mode  <= 0;
            m_pulse <= 1'b0;
            m_flag  <= 1'b0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            n_cyc   = m_cyc + 1;
            n_ref   = m_ref;
            n_tod   = m_tod;
            n_mode  = m_mode;
            n_pulse = 1'b0;
            h = m_tod / 3600;
            m = (m_tod / 60) % 60;
            case (m_mode)
                0: begin
                    if (key_mode) n_mode = 1;
                    else if ((n_cyc - m_ref) % TICK_DIV == 0) begin
                        n_tod   = (m_tod + 1) % 86400;
                        n_pulse = 1'b1;
                    end
                end
                1: begin
                    if (key_mode) n_mode = 2;
                    else if (key_inc) n_tod = m_tod - h * 3600 + ((h + 1) % 24) * 3600;
                end
                2: begin
                    if (key_mode) begin
                        n_mode = 0;
                        n_tod  = m_tod - (m_tod % 60);
                        n_ref  = n_cyc;
                    end else if (key_inc) begin
                        n_tod = m_tod - m * 60 + ((m + 1) % 60) * 60;
                    end
                end
                default: n_mode = 0;
            endcase
            m_cyc   <= n_cyc;
            m_ref   <= n_ref;
            m_tod   <= n_tod;
            m_mode  <= n_mode;
            m_pulse <= n_pulse;
            m_flag  <= (n_cyc % SCAN_DIV == 0);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_hour", int'(hour), m_tod / 3600);
            chk("cyc_min", int'(min), (m_tod / 60) % 60);
            chk("cyc_sec", int'(sec), m_tod % 60);
            chk("cyc_mode", int'(mode), m_mode);
            chk("cyc_sec_pulse", int'(sec_pulse), int'(m_pulse));
            chk("cyc_flag_scan", int'(flag_scan), int'(m_flag));
        end
    end

    task automatic press(input bit m, input bit i);
        key_mode = m;
        key_inc  = i;
        @(negedge clk);
        key_mode = 1'b0;
        key_inc  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_time(input int hinc, input int minc);
        do_reset();
        press(1'b1, 1'b0);
        repeat (hinc) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (minc) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
    endtask

    task automatic chk_time(input string name, input int h, input int m, input int s);
        chk({name, "_hour"}, int'(hour), h);
        chk({name, "_min"}, int'(min), m);
        chk({name, "_sec"}, int'(sec), s);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        repeat (2) @(negedge clk);
        chk_time("reset", 22, 46, 40);
        chk("reset_mode", int'(mode), 0);
        chk("reset_pulse", int'(sec_pulse), 0);
        chk("reset_flag", int'(flag_scan), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("flag_early", int'(flag_scan), 0);
        @(negedge clk);
        chk("flag_third", int'(flag_scan), 1);
        chk("pulse_early", int'(sec_pulse), 0);
        @(negedge clk);
        chk("first_pulse", int'(sec_pulse), 1);
        chk("first_sec", int'(sec), 41);

        set_time(3, 20);
        chk_time("setseq", 1, 6, 0);
        chk("setseq_mode", int'(mode), 0);
        repeat (3) begin
            @(negedge clk);
            chk("setseq_nopulse", int'(sec_pulse), 0);
        end
        @(negedge clk);
        chk("setseq_pulse", int'(sec_pulse), 1);
        chk("setseq_sec", int'(sec), 1);

        set_time(1, 13);
        chk_time("load235900", 23, 59, 0);
        repeat (59 * TICK_DIV) @(negedge clk);
        chk_time("load235959", 23, 59, 59);
        repeat (TICK_DIV) @(negedge clk);
        chk_time("midnight", 0, 0, 0);
        chk("midnight_pulse", int'(sec_pulse), 1);

        set_time(14, 48);
        repeat (59 * TICK_DIV) @(negedge clk);
        chk_time("load123459", 12, 34, 59);
        repeat (TICK_DIV) @(negedge clk);
        chk_time("carry_min", 12, 35, 0);

        set_time(14, 13);
        repeat (60 * TICK_DIV) @(negedge clk);
        chk_time("carry_hour", 13, 0, 0);

        do_reset();
        press(1'b1, 1'b1);
        chk("both_run_mode", int'(mode), 1);
        chk("both_run_hour", int'(hour), 22);
        press(1'b1, 1'b1);
        chk("both_sethour_mode", int'(mode), 2);
        chk("both_sethour_hour", int'(hour), 22);
        press(1'b1, 1'b0);

        do_reset();
        repeat (3) press(1'b0, 1'b1);
        chk_time("inc_in_run", 22, 46, 40);
        press(1'b1, 1'b0);
        chk("tick_vs_mode_pulse", int'(sec_pulse), 0);
        chk("tick_vs_mode_sec", int'(sec), 40);
        chk("tick_vs_mode_mode", int'(mode), 1);

        press(1'b1, 1'b0);
        repeat (5) press(1'b0, 1'b1);
        chk("setmin_min", int'(min), 51);
        do_reset();
        chk_time("rst_midset", 22, 46, 40);
        chk("rst_midset_mode", int'(mode), 0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk("rst_midset_flag", int'(flag_scan), 1);
        @(negedge clk);
        chk("rst_midset_pulse", int'(sec_pulse), 1);
        chk("rst_midset_sec", int'(sec), 41);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
